// File: rtl/bus8085_pkg.sv
// bus8085_pkg: shared state encoding and bus constants for the 8085-style bus cycle sequencer.
package bus8085_pkg;
    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;
    localparam logic IOM_MEM = 1'b0;
    localparam logic IOM_IO = 1'b1;
    localparam logic [7:0] IDLE_DATA = 8'hFF;
endpackage

// File: rtl/bus_wait_timer.sv
// bus_wait_timer: wait-state down-counter; expired flags the last permitted TW cycle.
module bus_wait_timer #(
    parameter int MAX_WAIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(MAX_WAIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt <= W'(MAX_WAIT);
        else if (clr) cnt <= W'(MAX_WAIT);
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    end
    assign expired = en && cnt == W'(1);
endmodule

// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl: sequences T1/T2/TW/T3 machine cycles toward the 8156 with registered, glitch-free strobes.
module bus_cycle_ctrl
    import bus8085_pkg::*;
#(
    parameter logic [7:0] RAM_PAGE = 8'h20,
    parameter int MAX_WAIT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        iom,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        err,
    input  logic        ready,
    output logic        ale,
    output logic [7:0]  addr_hi,
    output logic [7:0]  address,
    inout  wire  [7:0]  data,
    output logic        CSn,
    output logic        RDn,
    output logic        WRn,
    output logic        IOMn
);
    state_t state;
    logic we_r, iom_r, drive, expired, fin;
    logic [7:0] wdata_r;
    bus_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(state == T2),
        .en(state == TW),
        .expired(expired)
    );
    assign data = drive ? wdata_r : 8'bz;
    // Leaving T3 completes normally; running out of wait states aborts from TW.
    assign fin = state == T3 || (state == TW && !ready && expired);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            we_r <= 1'b0;
            iom_r <= IOM_IO;
            wdata_r <= 8'h00;
            drive <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            ale <= 1'b0;
            rdata <= 8'h00;
            address <= 8'h00;
            addr_hi <= 8'h00;
            CSn <= 1'b1;
            RDn <= 1'b1;
            WRn <= 1'b1;
            IOMn <= IOM_IO;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    state <= T1;
                    we_r <= we;
                    iom_r <= iom;
                    wdata_r <= wdata;
                    busy <= 1'b1;
                    ale <= 1'b1;
                    address <= addr[7:0];
                    addr_hi <= addr[15:8];
                    IOMn <= iom;
                    CSn <= !(iom == IOM_MEM && addr[15:8] == RAM_PAGE);
                end
                T1: begin
                    state <= T2;
                    ale <= 1'b0;
                    RDn <= we_r;
                    WRn <= !we_r;
                    drive <= we_r;
                end
                T2: state <= ready ? T3 : TW;
                TW: if (ready) state <= T3;
                T3: if (!we_r) rdata <= (iom_r == IOM_MEM && CSn) ? IDLE_DATA : data;
                default: state <= IDLE;
            endcase
            if (fin) begin
                state <= IDLE;
                busy <= 1'b0;
                done <= 1'b1;
                err <= state == TW;
                CSn <= 1'b1;
                RDn <= 1'b1;
                WRn <= 1'b1;
                IOMn <= IOM_IO;
                drive <= 1'b0;
            end
        end
    end
endmodule
